// File: rtl/ask_tx_scheduler_if.sv
// Control, mode-handshake and datapath-strobe bundle between the switch logic and the scheduler.
// Latency: wires only, no storage.
// Backpressure: mode_valid/mode_ready handshake; every other signal is a level or a one-cycle strobe.
interface ask_tx_scheduler_if #(
    parameter int unsigned PHASE_W = 32
);
    logic               start;
    logic               stop;
    logic [15:0]        burst_len;
    logic               mode_valid;
    logic [1:0]         mode_req;
    logic               mode_ready;
    logic               lfsr_bit;
    logic               lfsr_en;
    logic [1:0]         mod_sel;
    logic [PHASE_W-1:0] phase_inc;
    logic               tx_en;
    logic               busy;
    logic               done;
    logic [15:0]        sym_count;

    modport master (
        output start, stop, burst_len, mode_valid, mode_req, lfsr_bit,
        input  mode_ready, lfsr_en, mod_sel, phase_inc, tx_en, busy, done, sym_count
    );

    modport slave (
        input  start, stop, burst_len, mode_valid, mode_req, lfsr_bit,
        output mode_ready, lfsr_en, mod_sel, phase_inc, tx_en, busy, done, sym_count
    );
endinterface

// File: rtl/ask_tx_scheduler.sv
// Symbol-rate sequencer: symbol strobe, burst control, tx gating and symbol-aligned mode/phase selection.
// Latency: start -> tx_en next cycle; first lfsr_en SYM_DIV cycles later; mode applied the cycle after a tick.
// Backpressure: one pending mode request; mode_ready drops until it is applied (next clock in IDLE, next tick otherwise).
module ask_tx_scheduler #(
    parameter int unsigned        SYM_DIV   = 50000,
    parameter int unsigned        DIV_W     = 16,
    parameter int unsigned        PHASE_W   = 32,
    parameter logic [PHASE_W-1:0] F_CARRIER = 32'd85899,
    parameter logic [PHASE_W-1:0] F_SPACE   = 32'd42950,
    parameter logic [PHASE_W-1:0] F_MARK    = 32'd171799
) (
    input  logic          clk_i,
    input  logic          reset_n_i,   // asynchronous, active-low
    ask_tx_scheduler_if.slave sch
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SYM_DIV - 1);
    localparam logic [1:0]       MODE_FSK  = 2'd2;
    localparam logic [1:0]       MODE_RSVD = 2'd3;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [15:0]       sym_cnt_q, sym_cnt_d;
    logic [15:0]       burst_len_q, burst_len_d;
    logic              done_q, done_d;
    logic              pend_vld_q, pend_vld_d;
    logic [1:0]        pend_mode_q, pend_mode_d;
    logic [1:0]        mod_sel_q, mod_sel_d;

    logic active;
    logic tick;
    logic final_tick;
    logic mode_acc;

    // Strobes are decoded from registered state only, so lfsr_en is glitch-free.
    assign active     = (state_q != ST_IDLE);
    assign tick       = active && (div_cnt_q == DIV_LAST);
    assign final_tick = tick && (burst_len_q != 16'd0) && ((sym_cnt_q + 16'd1) == burst_len_q);
    assign mode_acc   = sch.mode_valid && !pend_vld_q;

    // Burst state machine: a final-symbol tick beats a simultaneous stop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (sch.start) state_d = ST_RUN;
            ST_RUN: begin
                if (final_tick)    state_d = ST_IDLE;
                else if (sch.stop) state_d = ST_STOPPING;
            end
            ST_STOPPING: if (tick) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Symbol divider, symbol counter, burst length latch and end-of-burst pulse.
    always_comb begin
        div_cnt_d   = (!active || tick) ? '0 : div_cnt_q + DIV_W'(1);
        sym_cnt_d   = sym_cnt_q;
        burst_len_d = burst_len_q;
        if (!active && sch.start) begin
            sym_cnt_d   = '0;
            burst_len_d = sch.burst_len;
        end else if (tick) begin
            sym_cnt_d = sym_cnt_q + 16'd1;
        end
        done_d = active && (state_d == ST_IDLE);
    end

    // Mode handshake: a captured request waits at least one cycle, so a tick in the capture cycle never applies it.
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_mode_d = pend_mode_q;
        mod_sel_d   = mod_sel_q;
        if (pend_vld_q && (!active || tick)) begin
            mod_sel_d  = pend_mode_q;
            pend_vld_d = 1'b0;
        end
        if (mode_acc && (sch.mode_req != MODE_RSVD)) begin
            pend_vld_d  = 1'b1;
            pend_mode_d = sch.mode_req;
        end
    end

    // State register; reset clears everything at once and suppresses the done pulse.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            sym_cnt_q   <= '0;
            burst_len_q <= '0;
            done_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_mode_q <= '0;
            mod_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            burst_len_q <= burst_len_d;
            done_q      <= done_d;
            pend_vld_q  <= pend_vld_d;
            pend_mode_q <= pend_mode_d;
            mod_sel_q   <= mod_sel_d;
        end
    end

    assign sch.lfsr_en    = tick;
    assign sch.tx_en      = active;
    assign sch.busy       = active;
    assign sch.done       = done_q;
    assign sch.sym_count  = sym_cnt_q;
    assign sch.mode_ready = !pend_vld_q;
    assign sch.mod_sel    = mod_sel_q;
    assign sch.phase_inc  = (mod_sel_q == MODE_FSK) ? (sch.lfsr_bit ? F_MARK : F_SPACE) : F_CARRIER;
endmodule

// File: tb/tb_ask_tx_scheduler.sv
// Scoreboard bench for ask_tx_scheduler: bursts are planned at the symbol level and checked per cycle.
// Latency: stimulus changes 1 time unit after posedge, monitor samples on negedge.
// Backpressure: one mode request per burst, optionally followed by a stalled second request.
module tb_ask_tx_scheduler;
    localparam int          D         = 4;
    localparam logic [31:0] F_CARRIER = 32'd85899;
    localparam logic [31:0] F_SPACE   = 32'd42950;
    localparam logic [31:0] F_MARK    = 32'd171799;

    typedef struct {
        int n;          // symbols in the burst (0 when aborted by reset)
        int old_mode;
        int new_mode;
        int t;          // relative RUN cycle of the tick that applies the mode
        int m;          // relative cycle of the request
        bit chg;
        bit rdy_lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ask_tx_scheduler_if #(.PHASE_W(32)) ifc();

    ask_tx_scheduler #(
        .SYM_DIV(D), .DIV_W(16), .PHASE_W(32),
        .F_CARRIER(F_CARRIER), .F_SPACE(F_SPACE), .F_MARK(F_MARK)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .sch      (ifc)
    );

    exp_t sb_q[$];
    int   errors = 0, checks = 0;
    int   model_mode = 0, last_n = 0, exp_done = 0;
    int   done_seen = 0, stray = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int calc_n(input int len, input int s);
        int ns;
        if (s < 0) return len;
        ns = (s % D == D - 1) ? s / D + 2 : s / D + 1;
        if (len != 0 && ns > len) return len;
        return ns;
    endfunction

    function automatic int exp_mode(input exp_t e, input int r);
        return (e.chg && r > e.t) ? e.new_mode : e.old_mode;
    endfunction

    function automatic logic [31:0] exp_phase(input int mode, input logic b);
        if (mode == 2) return b ? F_MARK : F_SPACE;
        return F_CARRIER;
    endfunction

    // Monitor: per-cycle observation of a burst, compared against the record at its end.
    exp_t cur;
    bit   in_burst = 1'b0;
    int   rel, tx_cnt, pulses, bad_pos, bad_busy, bad_mode, bad_rdy, bad_phase;
    logic exp_rdy;

    always @(negedge clk) begin
        if (!reset_n) begin
            if (in_burst && sb_q.size() > 0) void'(sb_q.pop_front());
            in_burst = 1'b0;
        end else if (ifc.tx_en) begin
            if (!in_burst) begin
                in_burst = 1'b1;
                rel = 0; tx_cnt = 0; pulses = 0; bad_pos = 0;
                bad_busy = 0; bad_mode = 0; bad_rdy = 0; bad_phase = 0;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_entry: burst started with %0d expected records, required 1", sb_q.size());
                    cur = '{n: 0, old_mode: 0, new_mode: 0, t: -1, m: -1, chg: 1'b0, rdy_lo: 1'b0};
                end else begin
                    cur = sb_q[0];
                end
            end
            tx_cnt++;
            if (ifc.lfsr_en) begin
                pulses++;
                if (rel % D != D - 1) bad_pos++;
            end
            if (ifc.busy !== 1'b1) bad_busy++;
            if (ifc.done) stray++;
            if (int'(ifc.mod_sel) != exp_mode(cur, rel)) bad_mode++;
            exp_rdy = !(cur.rdy_lo && rel > cur.m && rel <= cur.t);
            if (ifc.mode_ready != exp_rdy) bad_rdy++;
            if (ifc.phase_inc != exp_phase(exp_mode(cur, rel), ifc.lfsr_bit)) bad_phase++;
            rel++;
        end else begin
            if (ifc.lfsr_en || ifc.busy) stray++;
            if (in_burst) begin
                in_burst = 1'b0;
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                check("tx_cycles",    tx_cnt, cur.n * D);
                check("lfsr_pulses",  pulses, cur.n);
                check("lfsr_pos_bad", bad_pos, 0);
                check("busy_bad",     bad_busy, 0);
                check("sym_count",    ifc.sym_count, cur.n);
                check("done_pulse",   ifc.done, 1);
                check("mode_bad",     bad_mode, 0);
                check("ready_bad",    bad_rdy, 0);
                check("phase_bad",    bad_phase, 0);
                check("final_mode",   ifc.mod_sel, cur.new_mode);
                check("final_ready",  ifc.mode_ready, 1);
                if (ifc.done) done_seen++;
            end else if (ifc.done) begin
                stray++;
            end
        end
    end

    task automatic idle_inputs();
        ifc.start = 1'b0; ifc.stop = 1'b0; ifc.mode_valid = 1'b0; ifc.mode_req = 2'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},       ifc.busy, 0);
        check({tag, "_tx_en"},      ifc.tx_en, 0);
        check({tag, "_lfsr_en"},    ifc.lfsr_en, 0);
        check({tag, "_done"},       ifc.done, 0);
        check({tag, "_sym_count"},  ifc.sym_count, 0);
        check({tag, "_mod_sel"},    ifc.mod_sel, 0);
        check({tag, "_mode_ready"}, ifc.mode_ready, 1);
        check({tag, "_phase_inc"},  ifc.phase_inc, F_CARRIER);
    endtask

    // One burst: len/stop rel cycle s/mode request at rel m with value v; abort_at >= 0 pulls reset at that rel cycle.
    task automatic run_burst(input int len, input int s, input int m, input int v, input bit stall,
                             input bit together, input bit noise, input int abort_at);
        exp_t e;
        int   n, last, b;
        n        = (abort_at >= 0) ? 0 : calc_n(len, s);
        e.n      = n;
        e.old_mode = model_mode;
        e.m      = m;
        e.rdy_lo = (m >= 0) && (v != 3);
        e.chg    = e.rdy_lo;
        e.new_mode = e.chg ? v : model_mode;
        e.t      = e.chg ? ((m + 1) / D) * D + D - 1 : -1;
        sb_q.push_back(e);
        if (e.chg) model_mode = v;
        b = (v + 1) % 3;

        ifc.start = 1'b1; ifc.burst_len = 16'(len); ifc.stop = together;
        @(posedge clk); #1;
        ifc.start = 1'b0; ifc.stop = 1'b0;
        last = (abort_at >= 0) ? abort_at : n * D;
        for (int r = 0; r < last; r++) begin
            ifc.lfsr_bit   = 1'($urandom);
            ifc.stop       = (r == s);
            ifc.mode_valid = (r == m) || (stall && e.chg && r > m && r <= e.t);
            ifc.mode_req   = (r == m) ? 2'(v) : 2'(b);
            ifc.start      = noise && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        idle_inputs();
        if (abort_at >= 0) begin
            reset_n = 1'b0;
            #1;
            check_reset_vals("abort");
            model_mode = 0;
            last_n = 0;
            @(posedge clk); #1;
            reset_n = 1'b1;
        end else begin
            exp_done++;
            last_n = n;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int len, s, n, m, v, nm;
        bit stall, tog;
        reset_n = 1'b0;
        ifc.lfsr_bit = 1'b0; ifc.burst_len = 16'd0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed bursts from the plan.
        run_burst(3, -1, -1, 0, 0, 0, 0, -1);   // 3 symbols, ticks at 3/7/11
        run_burst(0,  5, -1, 0, 0, 0, 0, -1);   // continuous, stop at 5 -> 2 symbols
        run_burst(0,  9,  1, 2, 1, 0, 0, -1);   // FSK request at 1 plus stalled second request
        run_burst(3, -1,  3, 1, 0, 0, 1, -1);   // request on a tick cycle, start noise in RUN
        run_burst(2, -1,  2, 3, 0, 0, 0, -1);   // reserved mode dropped
        run_burst(2,  4, -1, 0, 0, 1, 1, -1);   // start and stop together in IDLE
        run_burst(1,  3, -1, 0, 0, 0, 0, -1);   // stop on the final-symbol tick

        // Mode request while IDLE is applied on the next clock.
        nm = (model_mode + 1) % 3;
        ifc.mode_valid = 1'b1; ifc.mode_req = 2'(nm);
        @(posedge clk); #1;
        ifc.mode_valid = 1'b0;
        check("idle_ready_pending", ifc.mode_ready, 0);
        check("idle_mode_hold", ifc.mod_sel, model_mode);
        @(posedge clk); #1;
        model_mode = nm;
        check("idle_mode_apply", ifc.mod_sel, model_mode);
        check("idle_ready_back", ifc.mode_ready, 1);

        // Stop in IDLE is ignored.
        ifc.stop = 1'b1;
        @(posedge clk); #1;
        ifc.stop = 1'b0;
        check("idle_stop_busy", ifc.busy, 0);
        check("idle_stop_sym", ifc.sym_count, last_n);
        @(posedge clk); #1;
        check("idle_stop_busy2", ifc.busy, 0);

        // Randomized bursts.
        for (int i = 0; i < 25; i++) begin
            len = $urandom_range(0, 5);
            if (len == 0)                  s = $urandom_range(0, 20);
            else if ($urandom_range(0, 2) == 0) s = $urandom_range(0, len * D + 2);
            else                           s = -1;
            n = calc_n(len, s);
            if ($urandom_range(0, 1) == 1) begin
                m = $urandom_range(0, n * D - 2);
                v = $urandom_range(0, 3);
                stall = (v != 3) && ($urandom_range(0, 1) == 1);
            end else begin
                m = -1; v = 0; stall = 1'b0;
            end
            tog = (len != 0) && ($urandom_range(0, 4) == 0);
            run_burst(len, s, m, v, stall, tog, 1'($urandom), -1);
        end

        // Reset mid-burst at rel cycle 6, then a normal burst.
        run_burst(0, -1, 1, 2, 0, 0, 0, 6);
        run_burst(2, -1, -1, 0, 0, 0, 0, -1);

        check("sb_drained", sb_q.size(), 0);
        check("done_total", done_seen, exp_done);
        check("stray_activity", stray, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so a stuck design still reaches the summary line.
    initial begin
        #200000;
        errors++; checks++;
        $display("FAIL timeout: simulation time %0t exceeded bound", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ask_tx_scheduler.md
# ask_tx_scheduler

Symbol-rate sequencer for the modulation datapath. Generates the symbol-boundary strobe that advances the LFSR, runs fixed-length or continuous bursts, and gates the modulator output. Also owns modulation-mode selection (ASK / BPSK / FSK) and the DDS phase increment, applying mode changes only on symbol boundaries. Sits between the control/switch logic and the LFSR, DDS and modulator blocks.

## Interface
- SYM_DIV, 50000: clock cycles per symbol; must be ≥ 2 and < 2^DIV_W
- DIV_W, 16: divider counter width
- PHASE_W, 32: DDS phase-increment width
- F_CARRIER, 32'd85899: phase increment for ASK/BPSK
- F_SPACE, 32'd42950: FSK increment when lfsr_bit = 0
- F_MARK, 32'd171799: FSK increment when lfsr_bit = 1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin burst; honoured only in IDLE
- stop  in  1  end burst at the next symbol boundary; honoured only in RUN
- burst_len  in  16  symbols per burst, latched on start; 0 = continuous
- mode_valid  in  1  mode request valid
- mode_req  in  2  0 = ASK, 1 = BPSK, 2 = FSK, 3 = reserved
- mode_ready  out  1  scheduler can accept a mode request
- lfsr_bit  in  1  current LFSR output bit
- lfsr_en  out  1  one-cycle LFSR advance strobe at each symbol boundary
- mod_sel  out  2  active modulation mode
- phase_inc  out  PHASE_W  DDS phase increment
- tx_en  out  1  modulator output enable
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when a burst ends
- sym_count  out  16  symbols completed in the current or last burst

## Operation
- FSM states:
  - IDLE → RUN on start.
  - RUN → STOPPING on stop.
  - RUN → IDLE on the final-symbol tick.
  - STOPPING → IDLE on the next tick.
- Divider div_cnt: held at 0 in IDLE; counts 0..SYM_DIV-1 and wraps in RUN and STOPPING.
- tick = (RUN or STOPPING) and div_cnt == SYM_DIV-1. lfsr_en = tick, decoded from registers only.
- On each tick, sym_count increments, wrapping 0xFFFF → 0.
- Final-symbol tick: burst_len ≠ 0 and sym_count+1 == burst_len.
- Burst start: start in IDLE clears sym_count and div_cnt and latches burst_len.
- tx_en = 1 in RUN and STOPPING. busy follows the same condition.
- done: registered, high for the one cycle after the transition to IDLE.
- sym_count holds its final value until the next start.
- Mode handshake:
  - mode_ready = !pending.
  - mode_valid && mode_ready latches mode_req into the pending register.
  - In IDLE, the pending mode is applied on the next clock.
  - In RUN or STOPPING, the pending mode is applied on the next tick after capture, never on a tick in the same cycle as the capture.
  - A mode_req of 3 completes the handshake but is discarded; mod_sel is unchanged.
- phase_inc (combinational):
  - mod_sel == 2: lfsr_bit ? F_MARK : F_SPACE.
  - Otherwise: F_CARRIER.
- Ignored inputs: start outside IDLE, and stop outside RUN.
- start and stop together in IDLE: start wins.
- stop in the same cycle as the final-symbol tick: go to IDLE; done pulses once.

## Timing
- Reset values: IDLE, div_cnt 0, pending empty, lfsr_en 0, mod_sel 0, phase_inc F_CARRIER, tx_en 0, busy 0, done 0, sym_count 0, mode_ready 1.
- Reset asserted mid-burst: every output returns to its reset value immediately. No done pulse is produced.
- start sampled at edge k: tx_en and busy are high from cycle k+1.
- First tick falls in RUN cycle SYM_DIV-1.
- An N-symbol burst holds tx_en high for exactly N·SYM_DIV cycles and produces N lfsr_en pulses. done is high in the first cycle with tx_en low.
- A mode change takes effect on mod_sel in the cycle after the tick, aligned with the start of the new symbol.
- Every symbol is complete: tx_en never drops mid-symbol except on reset.

## Test plan
- SYM_DIV=4, start with burst_len=3 → tx_en high 12 cycles, lfsr_en pulses at RUN cycles 3, 7 and 11, sym_count=3, a single done pulse, busy low afterwards.
- burst_len=0, stop asserted in RUN cycle 5 → STOPPING, IDLE after the tick at cycle 7, sym_count=2, done pulses once.
- In RUN, mode_req=2 accepted at cycle 1:
  - mode_ready low until the cycle after the tick.
  - mod_sel=2 from cycle 4.
  - phase_inc follows lfsr_bit as F_MARK / F_SPACE.
  - A second request while pending is stalled.
- Mode request in the same cycle as a tick → applied at the following tick, not the current one. mode_req=3 → mod_sel unchanged, mode_ready stays 1.
- reset pulled low mid-burst at cycle 6 → all outputs at reset values in the same cycle, no done pulse. A later start runs a normal burst.
- start pulsed during RUN, and stop pulsed in IDLE → no effect on state, sym_count or div_cnt.
